cluster_merge_pipe: RTL and testbench



---
 rtl/cluster_pkg.sv | 16 +
 rtl/cluster_cmp_swap.sv | 58 +++++
 rtl/cluster_merge_pipe.sv | 138 +++++++++++++
 tb/tb_cluster_merge_pipe.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cluster_pkg.sv
// Shared defaults and types for the cluster merge pipeline.
// The optional discard counter is enabled with CLUSTER_MERGE_OVF_CNT_EN.
package cluster_pkg;

  localparam int MXADRBITS_DEF = 11;
  localparam int MXCNTBITS_DEF = 3;

  // An all-ones address marks an empty slot; it sorts after every real cluster.
  localparam logic [MXADRBITS_DEF-1:0] SENTINEL = '1;

  typedef struct packed {
    logic [MXADRBITS_DEF-1:0] adr;
    logic [MXCNTBITS_DEF-1:0] cnt;
  } cluster_t;

endpackage

// File: rtl/cluster_cmp_swap.sv
// One registered compare-exchange: the smaller address leaves on lo, ties keep a on lo.
module cluster_cmp_swap
  import cluster_pkg::*;
#(
  parameter int MXADRBITS = MXADRBITS_DEF,
  parameter int MXCNTBITS = MXCNTBITS_DEF
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [MXADRBITS-1:0] adr_a_i,
  input  logic [MXCNTBITS-1:0] cnt_a_i,
  input  logic [MXADRBITS-1:0] adr_b_i,
  input  logic [MXCNTBITS-1:0] cnt_b_i,
  output logic [MXADRBITS-1:0] adr_lo_o,
  output logic [MXCNTBITS-1:0] cnt_lo_o,
  output logic [MXADRBITS-1:0] adr_hi_o,
  output logic [MXCNTBITS-1:0] cnt_hi_o
);

  logic                 swap;
  logic [MXADRBITS-1:0] adr_lo_d, adr_lo_q, adr_hi_d, adr_hi_q;
  logic [MXCNTBITS-1:0] cnt_lo_d, cnt_lo_q, cnt_hi_d, cnt_hi_q;

  assign swap = (adr_a_i > adr_b_i);

  always_comb begin
    adr_lo_d = adr_a_i;
    cnt_lo_d = cnt_a_i;
    adr_hi_d = adr_b_i;
    cnt_hi_d = cnt_b_i;
    if (swap) begin
      adr_lo_d = adr_b_i;
      cnt_lo_d = cnt_b_i;
      adr_hi_d = adr_a_i;
      cnt_hi_d = cnt_a_i;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      adr_lo_q <= '1;
      cnt_lo_q <= '0;
      adr_hi_q <= '1;
      cnt_hi_q <= '0;
    end else begin
      adr_lo_q <= adr_lo_d;
      cnt_lo_q <= cnt_lo_d;
      adr_hi_q <= adr_hi_d;
      cnt_hi_q <= cnt_hi_d;
    end
  end

  assign adr_lo_o = adr_lo_q;
  assign cnt_lo_o = cnt_lo_q;
  assign adr_hi_o = adr_hi_q;
  assign cnt_hi_o = cnt_hi_q;

endmodule

// File: rtl/cluster_merge_pipe.sv
// Pipelined Batcher odd-even merge of two sorted cluster lists, keeping the lowest N.
// Define CLUSTER_MERGE_OVF_CNT_EN to build the saturating discarded-cluster counter.
module cluster_merge_pipe
  import cluster_pkg::*;
#(
  parameter int MXADRBITS  = MXADRBITS_DEF,
  parameter int MXCNTBITS  = MXCNTBITS_DEF,
  parameter int MXCLUSTERS = 8,
  parameter int MXPASSBITS = 3
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              valid_in,
  input  logic [MXPASSBITS-1:0]             pass_in,
  input  logic [2*MXCLUSTERS*MXADRBITS-1:0] adr_in,
  input  logic [2*MXCLUSTERS*MXCNTBITS-1:0] cnt_in,
  output logic                              valid_out,
  output logic [MXPASSBITS-1:0]             pass_out,
  output logic [MXCLUSTERS*MXADRBITS-1:0]   adr_out,
  output logic [MXCLUSTERS*MXCNTBITS-1:0]   cnt_out,
  output logic                              overflow_o,
  input  logic                              ovf_clr,
  output logic [15:0]                       ovf_cnt_o
);

  localparam int N  = MXCLUSTERS;
  localparam int S  = $clog2(2 * N);
  localparam int CW = $clog2(N + 1);
  localparam logic [MXADRBITS-1:0] EMPTY = '1;

  // Handshake: a word is taken on every clock edge where valid_in is high and
  // appears S edges later with valid_out high; there is no ready and no stall.
  logic [MXADRBITS-1:0]  adr_st [S+1][2*N];
  logic [MXCNTBITS-1:0]  cnt_st [S+1][2*N];
  logic [S-1:0]          vld_q;
  logic [MXPASSBITS-1:0] pass_q [S];
  logic [CW-1:0]         ndisc;

  for (genvar i = 0; i < 2 * N; i++) begin : g_in
    assign adr_st[0][i] = adr_in[i*MXADRBITS +: MXADRBITS];
    assign cnt_st[0][i] = cnt_in[i*MXCNTBITS +: MXCNTBITS];
  end

  for (genvar k = 0; k < S; k++) begin : g_stage
    localparam int D = N >> k;
    for (genvar i = 0; i < 2 * N; i++) begin : g_slot
      localparam bit LO = (k == 0) ? (i < N) : (((i / D) % 2 == 1) && (i + D < 2 * N));
      localparam bit HI = (k == 0) ? (i >= N) : (((i / D) >= 2) && ((i / D) % 2 == 0));
      if (LO) begin : g_cx
        cluster_cmp_swap #(
          .MXADRBITS(MXADRBITS),
          .MXCNTBITS(MXCNTBITS)
        ) u_cx (
          .clock   (clock),
          .reset_n (reset_n),
          .adr_a_i (adr_st[k][i]),
          .cnt_a_i (cnt_st[k][i]),
          .adr_b_i (adr_st[k][i+D]),
          .cnt_b_i (cnt_st[k][i+D]),
          .adr_lo_o(adr_st[k+1][i]),
          .cnt_lo_o(cnt_st[k+1][i]),
          .adr_hi_o(adr_st[k+1][i+D]),
          .cnt_hi_o(cnt_st[k+1][i+D])
        );
      end else if (!HI) begin : g_pass
        logic [MXADRBITS-1:0] adr_q;
        logic [MXCNTBITS-1:0] cnt_q;
        always_ff @(posedge clock or negedge reset_n) begin
          if (!reset_n) begin
            adr_q <= '1;
            cnt_q <= '0;
          end else begin
            adr_q <= adr_st[k][i];
            cnt_q <= cnt_st[k][i];
          end
        end
        assign adr_st[k+1][i] = adr_q;
        assign cnt_st[k+1][i] = cnt_q;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int j = 0; j < S; j++) pass_q[j] <= '0;
    end else begin
      vld_q     <= {vld_q[S-2:0], valid_in};
      pass_q[0] <= pass_in;
      for (int j = 1; j < S; j++) pass_q[j] <= pass_q[j-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_out
    assign adr_out[i*MXADRBITS +: MXADRBITS] = adr_st[S][i];
    assign cnt_out[i*MXCNTBITS +: MXCNTBITS] = cnt_st[S][i];
  end

  assign valid_out = vld_q[S-1];
  assign pass_out  = pass_q[S-1];

  // Real clusters that sorted into the upper half are lost from this word.
  always_comb begin
    ndisc = '0;
    for (int i = N; i < 2 * N; i++) begin
      if (adr_st[S][i] != EMPTY) ndisc = ndisc + CW'(1);
    end
  end

  assign overflow_o = vld_q[S-1] && (ndisc != '0);

`ifdef CLUSTER_MERGE_OVF_CNT_EN
  logic [15:0] ovf_cnt_d, ovf_cnt_q;
  logic [16:0] ovf_sum;

  always_comb begin
    ovf_sum   = {1'b0, ovf_cnt_q} + 17'(ndisc);
    ovf_cnt_d = ovf_cnt_q;
    if (ovf_clr) begin
      ovf_cnt_d = '0;
    end else if (vld_q[S-1]) begin
      ovf_cnt_d = ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ovf_cnt_q <= '0;
    else          ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_cnt_o = ovf_cnt_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf_cnt_o      = '0;
`endif

endmodule

// File: tb/tb_cluster_merge_pipe.sv
// Scoreboard bench for cluster_merge_pipe at N=8 with directed, hand-computed vectors.
module tb_cluster_merge_pipe;
  import cluster_pkg::*;

  localparam int N  = 8;
  localparam int A  = 11;
  localparam int C  = 3;
  localparam int P  = 3;
  localparam int S  = 4;
  localparam int EW = 1 + P + N * C + N * A;
`ifdef CLUSTER_MERGE_OVF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             valid_in = 1'b0;
  logic [P-1:0]     pass_in = '0;
  logic [2*N*A-1:0] adr_in = '1;
  logic [2*N*C-1:0] cnt_in = '0;
  logic             ovf_clr = 1'b0;
  logic             valid_out, overflow_o;
  logic [P-1:0]     pass_out;
  logic [N*A-1:0]   adr_out;
  logic [N*C-1:0]   cnt_out;
  logic [15:0]      ovf_cnt_o;

  cluster_merge_pipe dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .valid_in  (valid_in),
    .pass_in   (pass_in),
    .adr_in    (adr_in),
    .cnt_in    (cnt_in),
    .valid_out (valid_out),
    .pass_out  (pass_out),
    .adr_out   (adr_out),
    .cnt_out   (cnt_out),
    .overflow_o(overflow_o),
    .ovf_clr   (ovf_clr),
    .ovf_cnt_o (ovf_cnt_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            lat_q[$];
  int            errors = 0;
  int            checks = 0;
  int            exp_cnt = 0;
  bit            clean_idle = 1'b0;
  logic [A-1:0]  va [2*N];
  logic [C-1:0]  vc [2*N];
  logic [A-1:0]  ea [N];
  logic [C-1:0]  ec [N];
  logic [N*A-1:0] all_empty;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_vec();
    for (int i = 0; i < 2 * N; i++) begin va[i] = SENTINEL; vc[i] = '0; end
    for (int i = 0; i < N; i++) begin ea[i] = SENTINEL; ec[i] = '0; end
  endtask

  task automatic send(input logic [P-1:0] p, input logic ovf, input int nd);
    logic [EW-1:0] e;
    @(posedge clock); #1;
    valid_in = 1'b1;
    pass_in  = p;
    for (int i = 0; i < 2 * N; i++) begin
      adr_in[i*A +: A] = va[i];
      cnt_in[i*C +: C] = vc[i];
    end
    e = '0;
    for (int i = 0; i < N; i++) begin
      e[i*A +: A]           = ea[i];
      e[N*A + i*C +: C]     = ec[i];
    end
    e[N*A + N*C +: P] = p;
    e[EW-1]           = ovf;
    exp_q.push_back(e);
    lat_q.push_back(cyc);
    exp_cnt = (exp_cnt + nd > 65535) ? 65535 : exp_cnt + nd;
  endtask

  task automatic idle();
    @(posedge clock); #1;
    valid_in = 1'b0;
    pass_in  = clean_idle ? '0 : P'($urandom);
    for (int i = 0; i < 2 * N; i++) begin
      adr_in[i*A +: A] = clean_idle ? SENTINEL : A'($urandom);
      cnt_in[i*C +: C] = clean_idle ? '0 : C'($urandom);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin idle(); n++; end
    check("drain_timeout", 128'(exp_q.size()), 0);
    exp_q.delete();
    lat_q.delete();
    repeat (2) idle();
    @(negedge clock);
  endtask

  task automatic check_cnt(input string name);
    check(name, ovf_cnt_o, CNT_EN ? 128'(exp_cnt) : 128'(0));
  endtask

  // ---------------- directed vectors ----------------
  task automatic set_v1();  // A = 1..8, B empty
    clear_vec();
    for (int i = 0; i < N; i++) begin
      va[i] = A'(i + 1); vc[i] = C'(i + 1); ea[i] = A'(i + 1); ec[i] = C'(i + 1);
    end
  endtask

  task automatic set_v2();  // A even, B odd: 8 clusters lost
    clear_vec();
    for (int i = 0; i < N; i++) begin
      va[i] = A'(2 * i); vc[i] = C'(2 * i);
      va[N+i] = A'(2 * i + 1); vc[N+i] = C'(2 * i + 1);
      ea[i] = A'(i); ec[i] = C'(i);
    end
  endtask

  task automatic set_v3();  // equal addresses, lower slot first
    clear_vec();
    va[0] = 11'd5; vc[0] = 3'd1; va[N] = 11'd5; vc[N] = 3'd2;
    ea[0] = 11'd5; ec[0] = 3'd1; ea[1] = 11'd5; ec[1] = 3'd2;
  endtask

  task automatic set_v4();  // B entirely below A
    clear_vec();
    for (int i = 0; i < N; i++) begin
      va[i] = A'(10 + i); vc[i] = 3'd5;
      va[N+i] = A'(i); vc[N+i] = C'(i);
      ea[i] = A'(i); ec[i] = C'(i);
    end
  endtask

  task automatic set_v5();  // sparse interleave, 5 clusters total
    clear_vec();
    va[0] = 11'd3; vc[0] = 3'd1; va[1] = 11'd9; vc[1] = 3'd2;
    va[N] = 11'd1; vc[N] = 3'd3; va[N+1] = 11'd4; vc[N+1] = 3'd4; va[N+2] = 11'd20; vc[N+2] = 3'd5;
    ea[0] = 11'd1; ec[0] = 3'd3; ea[1] = 11'd3; ec[1] = 3'd1; ea[2] = 11'd4; ec[2] = 3'd4;
    ea[3] = 11'd9; ec[3] = 3'd2; ea[4] = 11'd20; ec[4] = 3'd5;
  endtask

  task automatic set_v6();  // 7 + 7 clusters: 6 lost
    clear_vec();
    for (int i = 0; i < 7; i++) begin
      va[i] = A'(i); vc[i] = C'(i);
      va[N+i] = A'(10 + i); vc[N+i] = C'(10 + i);
      ea[i] = A'(i); ec[i] = C'(i);
    end
    ea[7] = 11'd10; ec[7] = 3'd2;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] e;
    int t;
    forever begin
      @(negedge clock);
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid_out", 128'(valid_out), 0);
        end else begin
          e = exp_q.pop_front();
          t = lat_q.pop_front();
          check("adr_out", adr_out, e[N*A-1:0]);
          check("cnt_out", cnt_out, e[N*A +: N*C]);
          check("pass_out", pass_out, e[N*A + N*C +: P]);
          check("overflow_o", overflow_o, e[EW-1]);
          check("latency", 128'(cyc - t), S);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    all_empty = '1;
    repeat (3) @(negedge clock);
    check("rst_valid_out", valid_out, 0);
    check("rst_adr_out", adr_out, all_empty);
    check("rst_cnt_out", cnt_out, 0);
    check("rst_pass_out", pass_out, 0);
    check("rst_overflow", overflow_o, 0);
    check("rst_ovf_cnt", ovf_cnt_o, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // back-to-back words with pass 1,2,3
    set_v1(); send(3'd1, 1'b0, 0);
    set_v2(); send(3'd2, 1'b1, 8);
    set_v3(); send(3'd3, 1'b0, 0);
    drain();
    check_cnt("ovf_cnt_after_v2");

    set_v4(); send(3'd4, 1'b1, 8); idle();
    set_v5(); send(3'd5, 1'b0, 0); idle(); idle();
    set_v6(); send(3'd6, 1'b1, 6);
    drain();
    check_cnt("ovf_cnt_after_v6");

    // reset with two words in flight
    set_v2(); send(3'd5, 1'b1, 8);
    set_v1(); send(3'd6, 1'b0, 0);
    clean_idle = 1'b1;
    idle();
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    lat_q.delete();
    exp_cnt = 0;
    #1;
    check("midrst_valid_out", valid_out, 0);
    check("midrst_adr_out", adr_out, all_empty);
    check("midrst_ovf_cnt", ovf_cnt_o, 0);
    repeat (2) idle();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idle();
      @(negedge clock);
      check("postrst_valid_out", valid_out, 0);
      check("postrst_adr_out", adr_out, all_empty);
      check("postrst_cnt_out", cnt_out, 0);
      check("postrst_pass_out", pass_out, 0);
    end
    clean_idle = 1'b0;
    set_v1(); send(3'd7, 1'b0, 0);
    drain();

    // clear in the same cycle as an increment
    set_v2(); send(3'd1, 1'b1, 8);
    drain();
    check_cnt("ovf_cnt_plus8");
    send(3'd2, 1'b1, 8);
    repeat (3) idle();
    @(posedge clock); #1; ovf_clr = 1'b1;
    @(posedge clock); #1; ovf_clr = 1'b0;
    exp_cnt = 0;
    drain();
    check_cnt("ovf_cnt_clr_wins");

    // saturation: 8191*8 = 0xFFF8, +6 = 0xFFFE, +8 -> 0xFFFF
    set_v2();
    for (int i = 0; i < 8191; i++) send(3'(i), 1'b1, 8);
    drain();
    check_cnt("ovf_cnt_fff8");
    set_v6(); send(3'd3, 1'b1, 6);
    drain();
    check_cnt("ovf_cnt_fffe");
    set_v2(); send(3'd4, 1'b1, 8);
    drain();
    check_cnt("ovf_cnt_sat");
    send(3'd5, 1'b1, 8);
    drain();
    check_cnt("ovf_cnt_sat_hold");
    @(posedge clock); #1; ovf_clr = 1'b1;
    @(posedge clock); #1; ovf_clr = 1'b0;
    exp_cnt = 0;
    @(negedge clock);
    check_cnt("ovf_cnt_cleared");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
